// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with pipeline hold.
module ex_muldiv_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ITER   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst_i,
    input  logic [DATA_W-1:0] op1_i,
    input  logic [DATA_W-1:0] op2_i,
    input  logic [4:0]        reg_wr_addr_i,
    input  logic              flush_i,
    output logic              hold_req_o,
    output logic              busy_o,
    output logic              result_valid_o,
    output logic [DATA_W-1:0] result_o,
    output logic              reg_wr_en_o,
    output logic [4:0]        reg_wr_addr_o
);

    localparam int unsigned CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [4:0]         rd_q, rd_d;
    logic               neg_q, neg_d;
    logic               special_q, special_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;

    logic              is_mop_c, start_c, div0_c, ovf_c, special_c;
    logic              s1_signed_c, s2_signed_c, neg1_c, neg2_c;
    logic [2:0]        funct3_c;
    logic [DATA_W-1:0] abs1_c, abs2_c, spec_res_c;
    logic              unused_inst_c;

    assign unused_inst_c = ^{inst_i[24:15], inst_i[11:7]};

    // Decode and operand preparation for the accept cycle
    always_comb begin
        is_mop_c    = (inst_i[6:0] == 7'b0110011) && (inst_i[31:25] == 7'b0000001);
        funct3_c    = inst_i[14:12];
        start_c     = (state_q == IDLE) && is_mop_c && !flush_i;
        s1_signed_c = (funct3_c == 3'b001) || (funct3_c == 3'b010) ||
                      (funct3_c == 3'b100) || (funct3_c == 3'b110);
        s2_signed_c = (funct3_c == 3'b001) || (funct3_c == 3'b100) || (funct3_c == 3'b110);
        neg1_c      = s1_signed_c && op1_i[DATA_W-1];
        neg2_c      = s2_signed_c && op2_i[DATA_W-1];
        abs1_c      = neg1_c ? -op1_i : op1_i;
        abs2_c      = neg2_c ? -op2_i : op2_i;
        div0_c      = funct3_c[2] && (op2_i == '0);
        ovf_c       = funct3_c[2] && !funct3_c[0] && (op1_i == 32'h8000_0000) &&
                      (op2_i == 32'hFFFF_FFFF);
        special_c   = div0_c || ovf_c;
        if (div0_c) spec_res_c = funct3_c[1] ? op1_i : '1;
        else        spec_res_c = funct3_c[1] ? '0 : 32'h8000_0000;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_c) state_d = special_c ? DONE : CALC;
                CALC:    if (cnt_q == CNT_W'(ITER - 1)) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            funct3_q  <= '0;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            funct3_q  <= funct3_d;
            rd_q      <= rd_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
        end
    end

    logic [DATA_W:0] mul_sum_c, div_rem_c, div_trial_c;

    // Capture on accept, then one multiply or divide step per CALC cycle
    always_comb begin
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        neg_d       = neg_q;
        special_d   = special_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        mul_sum_c   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (a_q[0] ? {1'b0, b_q} : '0);
        div_rem_c   = {acc_q[DATA_W-1:0], a_q[DATA_W-1]};
        div_trial_c = div_rem_c - {1'b0, b_q};
        if (start_c) begin
            cnt_d     = '0;
            funct3_d  = funct3_c;
            rd_d      = reg_wr_addr_i;
            // REM follows the dividend sign; everything else uses the sign product
            neg_d     = (funct3_c == 3'b110) ? neg1_c : (neg1_c ^ neg2_c);
            special_d = special_c;
            a_d       = abs1_c;
            b_d       = abs2_c;
            acc_d     = special_c ? {{DATA_W{1'b0}}, spec_res_c} : '0;
        end else if (state_q == CALC) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (funct3_q[2]) begin
                if (!div_trial_c[DATA_W]) begin
                    acc_d = {{(DATA_W-1){1'b0}}, div_trial_c};
                    a_d   = {a_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = {{(DATA_W-1){1'b0}}, div_rem_c};
                    a_d   = {a_q[DATA_W-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum_c, acc_q[DATA_W-1:1]};
                a_d   = {1'b0, a_q[DATA_W-1:1]};
            end
        end
    end

    logic [2*DATA_W-1:0] prod_c;
    logic [DATA_W-1:0]   quo_c, rem_c, res_c;

    // Output logic with sign fixup in DONE
    always_comb begin
        prod_c = neg_q ? -acc_q : acc_q;
        quo_c  = neg_q ? -a_q : a_q;
        rem_c  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        if (special_q) begin
            res_c = acc_q[DATA_W-1:0];
        end else begin
            case (funct3_q)
                3'b000:         res_c = acc_q[DATA_W-1:0];
                3'b100, 3'b101: res_c = quo_c;
                3'b110, 3'b111: res_c = rem_c;
                default:        res_c = prod_c[2*DATA_W-1:DATA_W];
            endcase
        end
        result_valid_o = (state_q == DONE) && !flush_i && !rst;
        hold_req_o     = !flush_i && !rst && (start_c || (state_q == CALC));
        busy_o         = (state_q == CALC);
        reg_wr_en_o    = result_valid_o;
        result_o       = result_valid_o ? res_c : '0;
        reg_wr_addr_o  = result_valid_o ? rd_q : '0;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M vectors, hold/busy timing, flush and reset abort.
module tb_ex_muldiv_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, op1_i, op2_i;
    logic [4:0]  reg_wr_addr_i;
    logic        flush_i;
    logic        hold_req_o, busy_o, result_valid_o, reg_wr_en_o;
    logic [31:0] result_o;
    logic [4:0]  reg_wr_addr_o;

    ex_muldiv_unit dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .op1_i(op1_i), .op2_i(op2_i),
        .reg_wr_addr_i(reg_wr_addr_i), .flush_i(flush_i), .hold_req_o(hold_req_o),
        .busy_o(busy_o), .result_valid_o(result_valid_o), .result_o(result_o),
        .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Monitor: pop the scoreboard on every result strobe
    always @(negedge clk) begin
        if (!rst) begin
            if (result_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'(result_valid_o), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", result_o, e.res);
                    check("rd", 32'(reg_wr_addr_o), 32'(e.rd));
                    check("strobe_cycle", 32'(cyc), 32'(e.cyc));
                    check("wr_en", 32'(reg_wr_en_o), 32'd1);
                end
            end else if (reg_wr_en_o || result_o != 0 || reg_wr_addr_o != 0) begin
                check("idle_outputs", {reg_wr_en_o, reg_wr_addr_o, result_o[25:0]}, 32'd0);
            end
        end
    end

    function automatic logic [31:0] mop(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    // Issue one op, check hold/busy every cycle until its result cycle
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] res, input int lat);
        int t;
        exp_t e;
        @(posedge clk); #1;
        inst_i = mop(f3, rd); op1_i = a; op2_i = b; reg_wr_addr_i = rd;
        t = cyc;
        e.res = res; e.rd = rd; e.cyc = t + lat;
        exp_q.push_back(e);
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            check("hold_req", 32'(hold_req_o), 32'(i < lat));
            check("busy", 32'(busy_o), 32'(i >= 1 && i < lat));
            if (i == 1) begin
                op1_i = $urandom; op2_i = $urandom; reg_wr_addr_i = 5'($urandom);
            end
        end
    endtask

    // Start a DIV and abort it after abort_at cycles via flush or reset
    task automatic abort_op(input logic use_rst, input int abort_at);
        @(posedge clk); #1;
        inst_i = mop(3'b100, 5'd9); op1_i = 32'd1000; op2_i = 32'd3; reg_wr_addr_i = 5'd9;
        for (int i = 0; i < abort_at; i++) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1; else flush_i = 1'b1;
        if (!use_rst) begin
            @(negedge clk);
            check("flush_hold", 32'(hold_req_o), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; flush_i = 1'b0; inst_i = NOP;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check(use_rst ? "rst_abort_busy" : "flush_abort_busy", 32'(busy_o), 32'd0);
            check(use_rst ? "rst_abort_hold" : "flush_abort_hold", 32'(hold_req_o), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush_i = 1'b0; inst_i = NOP; op1_i = '0; op2_i = '0; reg_wr_addr_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", 32'(hold_req_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_valid", 32'(result_valid_o), 32'd0);
        #1; rst = 1'b0;

        // Non-M R-type (ADD) and NOP are ignored
        @(posedge clk); #1;
        inst_i = 32'h0020_81B3; op1_i = 32'd5; op2_i = 32'd6;
        repeat (4) begin
            @(negedge clk);
            check("non_m_hold", 32'(hold_req_o), 32'd0);
            check("non_m_busy", 32'(busy_o), 32'd0);
        end

        // Back-to-back ops with the instruction held through DONE
        run_op(3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
        run_op(3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33);
        run_op(3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33);
        run_op(3'b010, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 33);
        run_op(3'b010, 32'hFFFF_FFFF,  32'h8000_0000, 5'd10, 32'hFFFF_FFFF, 33);
        run_op(3'b001, 32'h8000_0000,  32'h8000_0000, 5'd11, 32'h4000_0000, 33);
        run_op(3'b100, 32'hFFFF_FFF9,  32'd2,         5'd12, 32'hFFFF_FFFD, 33);
        run_op(3'b110, 32'hFFFF_FFF9,  32'd2,         5'd13, 32'hFFFF_FFFF, 33);
        run_op(3'b101, 32'd100,        32'd7,         5'd14, 32'd14,        33);
        run_op(3'b111, 32'd100,        32'd7,         5'd15, 32'd2,         33);
        run_op(3'b100, 32'd100,        32'hFFFF_FFF9, 5'd16, 32'hFFFF_FFF2, 33);
        run_op(3'b110, 32'd100,        32'hFFFF_FFF9, 5'd17, 32'd2,         33);
        run_op(3'b110, 32'hFFFF_FF9C,  32'd7,         5'd18, 32'hFFFF_FFFE, 33);
        run_op(3'b101, 32'd5,          32'd0,         5'd19, 32'hFFFF_FFFF, 1);
        run_op(3'b111, 32'd5,          32'd0,         5'd20, 32'd5,         1);
        run_op(3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 1);
        run_op(3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd22, 32'd0,         1);
        run_op(3'b100, 32'd42,         32'd0,         5'd23, 32'hFFFF_FFFF, 1);
        run_op(3'b110, 32'hFFFF_FFF8,  32'd0,         5'd24, 32'hFFFF_FFF8, 1);
        run_op(3'b000, 32'h1234_5678,  32'd16,        5'd25, 32'h2345_6780, 33);
        @(posedge clk); #1;
        inst_i = NOP;

        abort_op(1'b0, 10);
        abort_op(1'b1, 5);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("pending_results", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
Execute-stage iterative multiply/divide unit for the RV32M extension. It consumes the instruction and operands registered by the decode-to-execute pipeline register and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. While busy it raises a pipeline hold request so the decode-to-execute register freezes its contents; it then returns a one-cycle register-writeback result.

Parameters:
DATA_W, 32, operand/result width; only 32 is supported.
ITER, 32, radix-2 iterations per non-trivial operation; must equal DATA_W.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-high
inst_i  in  32  instruction from decode-to-execute register (NOP = 32'h00000013)
op1_i  in  32  rs1 operand
op2_i  in  32  rs2 operand
reg_wr_addr_i  in  5  destination register index
flush_i  in  1  execute-stage jump/flush; aborts any operation
hold_req_o  out  1  hold request to pipeline controller (drives hold_flag >= 3'b010)
busy_o  out  1  unit in CALC state
result_valid_o  out  1  one-cycle result strobe
result_o  out  32  result, valid when result_valid_o=1, else 0
reg_wr_en_o  out  1  equals result_valid_o
reg_wr_addr_o  out  5  captured rd, valid with result_valid_o, else 0

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Decode: M-op when inst_i[6:0]=7'b0110011 and inst_i[31:25]=7'b0000001; funct3 = inst_i[14:12] (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
- Reset: state=IDLE, counter=0. All outputs 0.
- States: IDLE, CALC, DONE.
- IDLE: start = M-op & ~flush_i.
  - On start, capture funct3, rd, operand signs and magnitudes.
  - Signed operands (MULH/MULHSU rs1; MULH rs2; DIV/REM both) are converted to absolute value. Unsigned operands pass through unchanged.
  - Divide-by-zero or signed overflow (op1=32'h80000000, op2=32'hFFFFFFFF with DIV/REM) -> DONE with the special result. Otherwise -> CALC with counter=0.
- hold_req_o = (IDLE & start) | CALC. It is asserted combinationally in the accept cycle, so the decode-to-execute register holds the instruction.
- CALC:
  - Multiply: shift-add, 64-bit accumulator, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle, 33-bit partial remainder.
  - Counter increments each cycle. After counter=ITER-1 -> DONE.
- DONE:
  - Apply sign fixup.
  - MUL = low 32 bits of product. MULH* = high 32 bits of the signed 64-bit product; negate the full 64 bits when the signs differ.
  - DIV quotient is negated if the operand signs differ. REM takes the dividend's sign.
  - result_valid_o=1, reg_wr_en_o=1 for exactly one cycle. hold_req_o=0. Next state IDLE.
  - DONE never starts a new op even though inst_i still shows the same M-op this cycle.
- Latency: accept cycle T.
  - Normal op: result_valid_o at T+ITER+1 (T+33).
  - Special case: result_valid_o at T+1.
- Special results:
  - DIV/DIVU by 0 -> 32'hFFFFFFFF.
  - REM/REMU by 0 -> op1.
  - DIV overflow -> 32'h80000000.
  - REM overflow -> 0.
- flush_i in any state: next state IDLE, no result_valid_o. hold_req_o is forced 0 in that cycle.
- rst mid-operation: IDLE next edge, no result strobe, captured data discarded.
- Non-M instructions (including NOP): ignored, all outputs 0.
- Operands are captured at accept. Later changes of op1_i/op2_i do not affect the result.

Test Plan:
- MUL op1=7, op2=32'hFFFFFFFD -> hold_req_o high T..T+32; result_o=32'hFFFFFFEB, reg_wr_en_o=1 at T+33 only, reg_wr_addr_o=captured rd.
- MULHU 32'hFFFFFFFF x 32'hFFFFFFFF -> 32'hFFFFFFFE. MULH same operands -> 0. MULHSU 32'hFFFFFFFF x 2 -> 32'hFFFFFFFF.
- DIV -7/2 -> 32'hFFFFFFFD; REM -7/2 -> 32'hFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each at T+33.
- DIVU 5/0 -> 32'hFFFFFFFF at T+1; REMU 5/0 -> 5 at T+1; DIV 32'h80000000/32'hFFFFFFFF -> 32'h80000000 at T+1; REM same operands -> 0.
- flush_i pulse at T+10 of a DIV -> busy_o=0 and hold_req_o=0 from T+11, no result_valid_o ever. rst at T+5 gives the same response.
- Back-to-back MUL then DIV, with the instruction held during each op -> exactly two result strobes at T+33 and T+33+1+33. No retrigger in the DONE cycle.
